// File: rtl/pilot_frame_scheduler.sv
// Pilot-insertion frame scheduler.
// Splits a sample stream into frames of cfg_frame_len output slots. A pilot word
// goes in slot 0 and again after every cfg_pilot_interval data samples; data
// samples fill the other slots. A single output register gives full ready/valid
// backpressure. Configuration is shadowed at frame boundaries.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | waiting for start; config is validated when start arrives
// ST_PILOT | next slot is a pilot, loaded as soon as the output stage is free
// ST_DATA  | next slot is a data sample, loaded on an input handshake
module pilot_frame_scheduler #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 13,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LEN_W-1:0]  cfg_frame_len,
    input  logic [LEN_W-1:0]  cfg_pilot_interval,
    input  logic [DATA_W-1:0] cfg_pilot_value,
    input  logic [FCNT_W-1:0] cfg_num_frames,
    input  logic              start,
    input  logic              stop,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_pilot,
    output logic              m_sof,
    output logic              m_eof,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              cfg_error,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PILOT = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [LEN_W-1:0]    len_q,       len_d;
    logic [LEN_W-1:0]    intv_q,      intv_d;
    logic [DATA_W-1:0]   pval_q,      pval_d;
    logic [FCNT_W-1:0]   nfr_q,       nfr_d;
    logic [LEN_W-1:0]    slot_q,      slot_d;
    logic [LEN_W-1:0]    pil_q,       pil_d;
    logic                stop_pend_q, stop_pend_d;
    logic [FCNT_W-1:0]   fcnt_q,      fcnt_d;
    logic                cerr_q,      cerr_d;
    logic                done_q,      done_d;
    logic [DATA_W-1:0]   mdata_q,     mdata_d;
    logic                mvalid_q,    mvalid_d;
    logic                mpilot_q,    mpilot_d;
    logic                msof_q,      msof_d;
    logic                meof_q,      meof_d;

    logic                out_free;
    logic                load_pilot;
    logic                load_data;
    logic                last_slot;
    logic [LEN_W-1:0]    pil_new;
    logic [FCNT_W-1:0]   fcnt_inc;

    // Handshake qualifiers and slot bookkeeping shared by the FSM and output stage.
    always_comb begin
        out_free   = !mvalid_q || m_ready;
        load_pilot = (state_q == ST_PILOT) && out_free;
        load_data  = (state_q == ST_DATA) && out_free && s_valid;
        last_slot  = (slot_q == (len_q - LEN_W'(1)));
        pil_new    = load_pilot ? '0 : (pil_q + LEN_W'(1));
        fcnt_inc   = fcnt_q + FCNT_W'(1);
    end

    // Next-state, counters, shadow config and output-stage loading.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        intv_d      = intv_q;
        pval_d      = pval_q;
        nfr_d       = nfr_q;
        slot_d      = slot_q;
        pil_d       = pil_q;
        stop_pend_d = stop_pend_q;
        fcnt_d      = fcnt_q;
        cerr_d      = cerr_q;
        done_d      = 1'b0;
        mdata_d     = mdata_q;
        mvalid_d    = mvalid_q;
        mpilot_d    = mpilot_q;
        msof_d      = msof_q;
        meof_d      = meof_q;

        // A beat that is accepted and not replaced leaves the output stage empty.
        if (mvalid_q && m_ready) begin
            mvalid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((cfg_frame_len < LEN_W'(2)) || (cfg_pilot_interval == '0)) begin
                        cerr_d = 1'b1;
                    end else begin
                        len_d       = cfg_frame_len;
                        intv_d      = cfg_pilot_interval;
                        pval_d      = cfg_pilot_value;
                        nfr_d       = cfg_num_frames;
                        cerr_d      = 1'b0;
                        fcnt_d      = '0;
                        slot_d      = '0;
                        pil_d       = '0;
                        stop_pend_d = 1'b0;
                        state_d     = ST_PILOT;
                    end
                end
            end

            ST_PILOT, ST_DATA: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (load_pilot || load_data) begin
                    mdata_d  = load_pilot ? pval_q : s_data;
                    mvalid_d = 1'b1;
                    mpilot_d = load_pilot;
                    msof_d   = (slot_q == '0);
                    meof_d   = last_slot;
                    pil_d    = pil_new;
                    if (last_slot) begin
                        fcnt_d = fcnt_inc;
                        if (stop_pend_q || ((nfr_q != '0) && (fcnt_inc == nfr_q))) begin
                            state_d     = ST_IDLE;
                            done_d      = 1'b1;
                            stop_pend_d = 1'b0;
                        end else begin
                            // Frame boundary: pick up whatever config is present now.
                            len_d   = cfg_frame_len;
                            intv_d  = cfg_pilot_interval;
                            pval_d  = cfg_pilot_value;
                            nfr_d   = cfg_num_frames;
                            slot_d  = '0;
                            pil_d   = '0;
                            state_d = ST_PILOT;
                        end
                    end else begin
                        slot_d  = slot_q + LEN_W'(1);
                        state_d = (pil_new == intv_q) ? ST_PILOT : ST_DATA;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset empties the output stage at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            intv_q      <= '0;
            pval_q      <= '0;
            nfr_q       <= '0;
            slot_q      <= '0;
            pil_q       <= '0;
            stop_pend_q <= 1'b0;
            fcnt_q      <= '0;
            cerr_q      <= 1'b0;
            done_q      <= 1'b0;
            mdata_q     <= '0;
            mvalid_q    <= 1'b0;
            mpilot_q    <= 1'b0;
            msof_q      <= 1'b0;
            meof_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            intv_q      <= intv_d;
            pval_q      <= pval_d;
            nfr_q       <= nfr_d;
            slot_q      <= slot_d;
            pil_q       <= pil_d;
            stop_pend_q <= stop_pend_d;
            fcnt_q      <= fcnt_d;
            cerr_q      <= cerr_d;
            done_q      <= done_d;
            mdata_q     <= mdata_d;
            mvalid_q    <= mvalid_d;
            mpilot_q    <= mpilot_d;
            msof_q      <= msof_d;
            meof_q      <= meof_d;
        end
    end

    // Output ports.
    always_comb begin
        s_ready   = (state_q == ST_DATA) && out_free;
        m_data    = mdata_q;
        m_valid   = mvalid_q;
        m_pilot   = mpilot_q;
        m_sof     = msof_q;
        m_eof     = meof_q;
        busy      = (state_q != ST_IDLE);
        frame_cnt = fcnt_q;
        cfg_error = cerr_q;
        done      = done_q;
    end

endmodule

// File: doc/pilot_frame_scheduler.md
Name: pilot_frame_scheduler

Overview:
- Frame-level controller for the pilot-insertion datapath.
- Sequences a 32-bit sample stream into frames of cfg_frame_len output slots. Emits the pilot word at slot 0 and after every cfg_pilot_interval data samples. Data samples pass through in the remaining slots.
- Full ready/valid backpressure on both sides. Config is shadowed at frame boundaries. Runs for a programmed number of frames, or continuously.

Parameters:
- DATA_W, 32, sample and pilot word width
- LEN_W, 13, width of frame length, slot and interval counters
- FCNT_W, 16, width of the frame-count register and counter

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_frame_len  in  LEN_W  output slots per frame, pilots included
- cfg_pilot_interval  in  LEN_W  data samples between consecutive pilots
- cfg_pilot_value  in  DATA_W  pilot word
- cfg_num_frames  in  FCNT_W  frames to run; 0 = continuous
- start  in  1  single-cycle pulse, begins operation from IDLE
- stop  in  1  single-cycle pulse, ends operation after the current frame
- s_data  in  DATA_W  input sample
- s_valid  in  1  input sample valid
- s_ready  out  1  scheduler accepts input sample
- m_data  out  DATA_W  output slot word
- m_valid  out  1  output valid
- m_ready  in  1  downstream accepts
- m_pilot  out  1  current m_data is a pilot
- m_sof  out  1  current m_data is slot 0
- m_eof  out  1  current m_data is slot cfg_frame_len-1
- busy  out  1  state != IDLE
- frame_cnt  out  FCNT_W  frames completed since last start
- cfg_error  out  1  sticky; last start was rejected
- done  out  1  single-cycle pulse when returning to IDLE

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0, state IDLE.
  - Shadow config, slot_cnt, pil_cnt and stop_pend cleared.
  - m_valid drops immediately; no partial beat is completed.
- Output register:
  - One output stage holds m_data and the m_pilot/m_sof/m_eof flags.
  - Loads when (!m_valid || m_ready) and a slot word is available. Otherwise m_* holds stable while m_valid=1 && !m_ready.
- Latency: a sample accepted at edge n is presented on m at edge n+1.
- s_ready = (state==DATA) && (!m_valid || m_ready). It is combinational from state and output status; it never depends on s_valid.
- States:
  - IDLE:
    - On start, validate config. Invalid means cfg_frame_len<2 or cfg_pilot_interval==0.
    - Invalid: set cfg_error=1, stay IDLE.
    - Valid: latch all cfg_* into shadow, clear cfg_error, frame_cnt=0, slot_cnt=0, pil_cnt=0, go to PILOT.
  - PILOT: when the output register is free, load the shadow pilot value with m_pilot=1, then advance the slot.
  - DATA: on an s handshake, load s_data with m_pilot=0, pil_cnt+1, then advance the slot. If s_valid is low, wait indefinitely; this is not an error and no slot advances.
- Slot advance:
  - If slot_cnt==len-1, the word just loaded carries m_eof=1 and end-of-frame processing runs (below).
  - Otherwise slot_cnt+1. The next state is PILOT if the new pil_cnt==interval, else DATA.
  - pil_cnt resets to 0 on every pilot load.
- m_sof=1 exactly when the loaded word is slot 0.
- End of frame:
  - frame_cnt+1.
  - If stop_pend, or (num_frames!=0 and frame_cnt+1==num_frames): go to IDLE, pulse done, clear stop_pend.
  - Else re-latch cfg_* into shadow (no validation; an invalid value takes effect unchanged), slot_cnt=0, pil_cnt=0, go to PILOT.
  - The last beat may still be pending on m when IDLE is entered. It completes normally, and busy deasserts at the same edge done pulses.
- Shadowing: cfg_* changes mid-frame have no effect until the next frame boundary.
- interval >= len-1: exactly one pilot per frame, at slot 0.
- Frame length exactly matches the pattern: a frame may end on a data slot or a pilot slot. Either way the next frame starts with a pilot.
- start while busy: ignored.
- stop while IDLE: ignored. stop while busy: sets stop_pend. start and stop in the same cycle in IDLE: start wins, stop ignored.
- frame_cnt wraps modulo 2^FCNT_W in continuous mode.
- Counter arithmetic is unsigned LEN_W-bit with no overflow, given len <= 2^LEN_W-1.

Test Plan:
- Pattern: len=8, interval=3, pilot=0xA5A5_0001, num_frames=1, inputs 1,2,3,...
  - Required m sequence: P,1,2,3,P,4,5,6, with m_pilot on slots 0 and 4, m_sof on slot 0, m_eof on 6.
  - done pulses once; frame_cnt=1.
- Backpressure: same config, m_ready toggled 1-0-0-1 randomly, s_valid random.
  - m_* stable whenever valid && !ready.
  - No sample lost or duplicated; output order identical to the unstalled run.
- Multi-frame and shadowing: num_frames=3, len=6, interval=10.
  - Expect P,D×5 per frame; frame_cnt reaches 3, then done.
  - Changing len to 4 mid-frame 1 takes effect at frame 2: P,D×3.
- Invalid config: start with len=1, then with interval=0.
  - cfg_error=1, busy stays 0, no m_valid.
  - A subsequent valid start clears cfg_error.
- Stop: continuous mode, stop at slot 3 of frame 2.
  - Frame 2 completes through m_eof, then IDLE with done.
  - frame_cnt=2; start coincident with stop in IDLE begins a run.
- Reset mid-frame: deassert rst_n asynchronously at slot 5 while m_valid=1 and m_ready=0.
  - All outputs 0 immediately.
  - After release and start, output restarts at slot 0 with a pilot.
